// File: rtl/wb_mem_tester_pkg.sv
// Shared types and constants for the Wishbone memory tester.
package wb_mem_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_REQ = 3'd1,
    ST_WR_GAP = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_GAP = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PAT_INDEX  = 2'd0,
    PAT_NINDEX = 2'd1,
    PAT_LFSR   = 2'd2,
    PAT_CONST  = 2'd3
  } pattern_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Right-shifting Galois LFSR step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // An all-zero state would lock the LFSR, so seed 0 starts from 1.
  function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/wb_pattern_gen.sv
// Test-pattern source: word for the given index; LFSR advances on step, reloads on load.
module wb_pattern_gen
  import wb_mem_tester_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [1:0]            pattern,
  input  logic [31:0]           seed,
  input  logic [ADDR_WIDTH-1:0] index,
  output logic [31:0]           word_c
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)      lfsr_d = lfsr_seed(seed);
    else if (step) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 32'h1;
    else        lfsr_q <= lfsr_d;
  end

  // Word is taken from the next-state LFSR so the caller can register it alongside index.
  always_comb begin
    case (pattern_e'(pattern))
      PAT_INDEX:  word_c = 32'(index);
      PAT_NINDEX: word_c = ~32'(index);
      PAT_LFSR:   word_c = lfsr_d;
      default:    word_c = seed;
    endcase
  end

endmodule

// File: rtl/wb_mem_tester.sv
// Wishbone memory tester: writes a pattern over a region, reads it back and reports first mismatch.
module wb_mem_tester
  import wb_mem_tester_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rstn_i,
  input  logic                  start_i,
  input  logic [1:0]            pattern_i,
  input  logic [31:0]           seed_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH-1:0] err_idx_o,
  output logic [31:0]           err_dat_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [31:0]           wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_ack_i
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [1:0]            pattern_q, pattern_d;
  logic [31:0]           seed_q, seed_d;
  logic [31:0]           tmo_q, tmo_d;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0] err_idx_q, err_idx_d;
  logic [31:0]           err_dat_q, err_dat_d;
  logic                  cyc_q, cyc_d, we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           adr_q, adr_d, dat_q, dat_d, exp_q, exp_d;
  logic                  load_c, step_c, last_c, tmo_hit_c;
  logic [31:0]           word_c;

  wb_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_pat (
    .clk     (wb_clk_i),
    .rst_n   (wb_rstn_i),
    .load    (load_c),
    .step    (step_c),
    .pattern (pattern_d),
    .seed    (seed_d),
    .index   (index_d),
    .word_c  (word_c)
  );

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    len_d     = len_q;
    pattern_d = pattern_q;
    seed_d    = seed_q;
    tmo_d     = '0;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    err_idx_d = err_idx_q;
    err_dat_d = err_dat_q;
    load_c    = 1'b0;
    step_c    = 1'b0;
    last_c    = (LEN_W'(index_q) + LEN_W'(1)) == len_q;
    tmo_hit_c = (tmo_q + 32'd1) >= 32'(TIMEOUT);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          pattern_d = pattern_i;
          seed_d    = seed_i;
          len_d     = len_i;
          index_d   = '0;
          timeout_d = 1'b0;
          pass_d    = (len_i == '0);
          load_c    = 1'b1;
          state_d   = (len_i == '0) ? ST_DONE : ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (wbm_ack_i) begin
          state_d = ST_WR_GAP;
          step_c  = 1'b1;
          if (last_c) begin
            index_d = '0;
            load_c  = 1'b1;
          end else begin
            index_d = index_q + ADDR_WIDTH'(1);
          end
        end else if (tmo_hit_c) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          err_idx_d = index_q;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      // Index is back at 0 here only after the final write, even for a full 2^ADDR_WIDTH region.
      ST_WR_GAP: state_d = (index_q == '0) ? ST_RD_REQ : ST_WR_REQ;
      ST_RD_REQ: begin
        if (wbm_ack_i) begin
          if (wbm_dat_i != exp_q) begin
            state_d   = ST_DONE;
            pass_d    = 1'b0;
            err_idx_d = index_q;
            err_dat_d = wbm_dat_i;
          end else if (last_c) begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_RD_GAP;
            step_c  = 1'b1;
            index_d = index_q + ADDR_WIDTH'(1);
          end
        end else if (tmo_hit_c) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          err_idx_d = index_q;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_RD_GAP: state_d = ST_RD_REQ;
      default:   state_d = ST_IDLE;
    endcase

    cyc_d  = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
    we_d   = (state_d == ST_WR_REQ);
    sel_d  = cyc_d ? 4'hF : 4'h0;
    adr_d  = cyc_d ? (BASE_ADDR + (32'(index_d) << 2)) : 32'h0;
    dat_d  = we_d ? word_c : 32'h0;
    exp_d  = word_c;
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      len_q     <= '0;
      pattern_q <= '0;
      seed_q    <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_idx_q <= '0;
      err_dat_q <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      len_q     <= len_d;
      pattern_q <= pattern_d;
      seed_q    <= seed_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_idx_q <= err_idx_d;
      err_dat_q <= err_dat_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      exp_q     <= exp_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign timeout_o = timeout_q;
  assign err_idx_o = err_idx_q;
  assign err_dat_o = err_dat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Scoreboard bench for wb_mem_tester: RAM slave model, expected-transfer queue, randomized runs.
module tb_wb_mem_tester;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TMO  = 255;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [1:0]  pat = 2'd0;
  logic [31:0] seed = 32'h0;
  logic [8:0]  len = 9'd0;
  logic        busy, done, pass, tmo_o;
  logic [7:0]  err_idx;
  logic [31:0] err_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack = 1'b0;

  always #5 clk = ~clk;

  wb_mem_tester #(.BASE_ADDR(BASE), .ADDR_WIDTH(8), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .start_i(start), .pattern_i(pat), .seed_i(seed),
    .len_i(len), .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo_o),
    .err_idx_o(err_idx), .err_dat_o(err_dat), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
    .wbm_we_o(we), .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );

  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; } bus_t;
  typedef struct { logic e_pass; logic e_tmo; logic [7:0] e_idx; logic [31:0] e_dat;
                   logic chk_idx; logic chk_dat; } fin_t;

  bus_t exp_bus[$];
  fin_t exp_fin[$];
  int   errors = 0, checks = 0;
  int   cfg_wait = 0, cfg_corrupt = -1, cfg_stall = -1;
  logic [31:0] mem [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Reference pattern: word i of the sequence defined by pattern code and seed.
  function automatic logic [31:0] ref_word(input logic [1:0] p, input logic [31:0] s, input int i);
    logic [31:0] r;
    case (p)
      2'd0: return 32'(i);
      2'd1: return ~32'(i);
      2'd2: begin
        r = (s == 32'h0) ? 32'h1 : s;
        for (int k = 0; k < i; k++) r = r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
        return r;
      end
      default: return s;
    endcase
  endfunction

  // Slave + monitor: acks transfers after cfg_wait cycles, pops and compares expectations.
  int          wait_cnt = 0, hi_cnt = 0, gap_cnt = 0, cur = 0;
  bit          in_gap = 0, done_prev = 0;
  logic [31:0] off;
  bus_t        eb;
  fin_t        ef;

  always @(negedge clk) begin
    if (!rstn) begin
      ack = 1'b0; wait_cnt = 0; hi_cnt = 0; gap_cnt = 0; in_gap = 0; done_prev = 0;
    end else begin
      if (ack) begin
        ack = 1'b0; wait_cnt = 0; hi_cnt = 0; in_gap = 1; gap_cnt = 0;
        check("cyc_low_after_ack", 32'(cyc), 32'd0);
      end
      if (!cyc) begin
        if (hi_cnt > 0) begin
          check("timeout_cycles", hi_cnt, TMO);
          hi_cnt = 0;
        end
        if (in_gap) begin
          if (busy) gap_cnt++;
          else in_gap = 0;
        end
      end else begin
        if (in_gap) begin
          check("gap_len", gap_cnt, 1);
          in_gap = 0;
        end
        hi_cnt++;
        off = adr - BASE;
        cur = int'(off[9:2]);
        if (we && cur == cfg_stall) begin
          // never acknowledged
        end else if (wait_cnt < cfg_wait) begin
          wait_cnt++;
        end else begin
          ack = 1'b1;
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_transfer: got adr %08h we %0d, want no transfer", adr, we);
          end else begin
            eb = exp_bus.pop_front();
            check("bus_we", 32'(we), 32'(eb.we));
            check("bus_adr", adr, eb.adr);
            check("bus_stb_sel", {27'd0, stb, sel}, {27'd0, 1'b1, 4'hF});
            if (eb.we) check("bus_wdat", dat_o, eb.dat);
          end
          if (we) mem[cur] = dat_o;
          else    dat_i = (cur == cfg_corrupt) ? 32'hDEAD_BEEF : mem[cur];
        end
      end
      if (done && !done_prev) begin
        if (exp_fin.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done_o=1, want no completion");
        end else begin
          ef = exp_fin.pop_front();
          check("pass", 32'(pass), 32'(ef.e_pass));
          check("timeout", 32'(tmo_o), 32'(ef.e_tmo));
          check("busy_in_done", 32'(busy), 32'd0);
          if (ef.chk_idx) check("err_idx", 32'(err_idx), 32'(ef.e_idx));
          if (ef.chk_dat) check("err_dat", err_dat, ef.e_dat);
        end
      end
      done_prev = done;
    end
  end

  task automatic push_bus(input logic w, input int i, input logic [31:0] d);
    bus_t b;
    b.we = w; b.adr = BASE + 32'(i) * 32'd4; b.dat = d;
    exp_bus.push_back(b);
  endtask

  task automatic run_test(input int n, input logic [1:0] p, input logic [31:0] s, input int w,
                          input int corrupt, input int stall, input bit noise);
    fin_t f;
    bit   got;
    cfg_wait = w; cfg_corrupt = corrupt; cfg_stall = stall;
    f = '{e_pass: 1'b1, e_tmo: 1'b0, e_idx: 8'd0, e_dat: 32'd0, chk_idx: 1'b0, chk_dat: 1'b0};
    for (int i = 0; i < n && i != stall; i++) push_bus(1'b1, i, ref_word(p, s, i));
    if (stall >= 0 && stall < n) begin
      f.e_pass = 1'b0; f.e_tmo = 1'b1; f.e_idx = 8'(stall); f.chk_idx = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        push_bus(1'b0, i, 32'h0);
        if (i == corrupt) begin
          f.e_pass = 1'b0; f.e_idx = 8'(i); f.e_dat = 32'hDEAD_BEEF;
          f.chk_idx = 1'b1; f.chk_dat = 1'b1;
          break;
        end
      end
    end
    exp_fin.push_back(f);
    @(negedge clk); start = 1'b1; len = 9'(n); pat = p; seed = s;
    @(negedge clk); start = 1'b0; len = 9'($urandom_range(1, 256)); pat = 2'($urandom); seed = $urandom;
    got = 0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(negedge clk);
      if (noise && c == 10) begin
        start = 1'b1; len = 9'($urandom_range(1, 256)); pat = 2'($urandom); seed = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1;
    end
    check("done_reached", 32'(got), 32'd1);
    repeat (2) @(negedge clk);
    check("bus_queue_empty", exp_bus.size(), 0);
    check("fin_queue_empty", exp_fin.size(), 0);
    exp_bus.delete();
    exp_fin.delete();
  endtask

  initial begin
    bit   found, saw_cyc;
    fin_t f;
    int   n, cor;

    repeat (3) @(negedge clk);
    check("rst_bus", {28'd0, cyc, stb, we, |sel}, 32'd0);
    check("rst_status", {28'd0, busy, done, pass, tmo_o}, 32'd0);
    check("rst_adr", adr, 32'd0);
    rstn = 1'b1;

    run_test(4, 2'd0, 32'h0, 0, -1, -1, 0);
    run_test(8, 2'd2, 32'h0000_ACE1, 3, -1, -1, 0);
    run_test(8, 2'd3, 32'h1234_5678, 0, 5, -1, 0);
    run_test(4, 2'd1, 32'h0, 0, -1, 2, 0);
    run_test(16, 2'd2, 32'h0, 1, -1, -1, 1);
    run_test(256, 2'd1, 32'h0, 0, -1, -1, 0);
    for (int t = 0; t < 6; t++) begin
      n   = $urandom_range(1, 20);
      cor = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      run_test(n, 2'($urandom), $urandom, $urandom_range(0, 2), cor, -1, 0);
    end

    // Reset during the read of index 3, then a zero-length test.
    cfg_wait = 2; cfg_corrupt = -1; cfg_stall = -1;
    for (int i = 0; i < 8; i++) push_bus(1'b1, i, 32'(i));
    for (int i = 0; i < 3; i++) push_bus(1'b0, i, 32'h0);
    @(negedge clk); start = 1'b1; len = 9'd8; pat = 2'd0; seed = 32'h0;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (cyc && !we && adr == BASE + 32'd12) found = 1;
    end
    check("rd3_reached", 32'(found), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("rst_mid_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_mid_adr", adr, 32'd0);
    check("rst_mid_err", {24'd0, err_idx} | err_dat, 32'd0);
    repeat (2) @(negedge clk);
    check("rst_bus_queue_empty", exp_bus.size(), 0);
    exp_bus.delete();
    f = '{e_pass: 1'b1, e_tmo: 1'b0, e_idx: 8'd0, e_dat: 32'd0, chk_idx: 1'b0, chk_dat: 1'b0};
    exp_fin.push_back(f);
    rstn = 1'b1; start = 1'b1; len = 9'd0; pat = 2'd1;
    @(posedge clk); #1;
    check("len0_done_pass", {30'd0, done, pass}, 32'd3);
    @(negedge clk); start = 1'b0;
    saw_cyc = 0;
    repeat (6) begin
      @(negedge clk);
      if (cyc || busy) saw_cyc = 1;
    end
    check("no_resume_after_reset", 32'(saw_cyc), 32'd0);
    check("len0_fin_queue_empty", exp_fin.size(), 0);

    run_test(5, 2'd3, 32'h0, 1, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
